grant_bus_mux: RTL and testbench
================================

Name: grant_bus_mux

Overview:
- Sits directly downstream of the 4-requester fixed-priority arbiter and consumes its one-hot gnt vector.
- Locks onto the granted requester and steers that requester's multi-beat packet onto one shared valid/ready output bus.
- Releases ownership on the last beat; a new grant is only sampled once the current packet has completed.

Parameters:
- N_REQ, 4, number of requesters; equals arbiter gnt width.
- DATA_W, 8, data width per requester.
- MAX_BEATS, 16, burst beat limit used by the optional truncation feature; must be ≥2.
- IDX_W, $clog2(N_REQ), width of the owner index (derived, not overridden).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- gnt  input  N_REQ  one-hot grant from arbiter.
- in_valid  input  N_REQ  per-requester beat valid.
- in_data  input  N_REQ*DATA_W  flattened per-requester data; requester i occupies [i*DATA_W +: DATA_W].
- in_last  input  N_REQ  per-requester last-beat flag.
- in_ready  output  N_REQ  per-requester ready.
- out_valid  output  1  shared bus valid.
- out_data  output  DATA_W  shared bus data.
- out_last  output  1  shared bus last (includes a forced last).
- out_ready  input  1  downstream ready.
- owner  output  IDX_W  index of the locked requester.
- busy  output  1  high in XFER.
- done  output  1  one-cycle pulse at release.
- trunc  output  1  one-cycle pulse with done when the burst was force-ended.

Behaviour:
- One clock; reset is asynchronous and active-low.
- While rst=0:
  - state is IDLE;
  - owner=0, beat_cnt=0;
  - busy, done and trunc are 0;
  - out_valid, out_last, out_data and all in_ready bits are 0.
- States:
  - IDLE: wait for gnt≠0. On the next edge, capture owner = index of the lowest set gnt bit, clear beat_cnt, and go to XFER. A multi-hot gnt is illegal; the lowest index wins.
  - XFER: busy=1. gnt is ignored, so ownership stays locked even if gnt changes.
  - RELEASE: one cycle. done=1, busy=0, all in_ready=0, out_valid=0. Next state is IDLE. owner holds its value until the next capture.
- XFER datapath (combinational):
  - out_valid = in_valid[owner], out_data = in_data slice[owner].
  - out_last = in_last[owner] | force_last.
  - in_ready[owner] = out_ready; all other in_ready bits = 0.
  - In IDLE and RELEASE, out_data = 0.
- Beat accepted when out_valid & out_ready in XFER; this increments beat_cnt.
- Accepted beat with out_last=1 → RELEASE on the next edge.
- Latency:
  - gnt seen in IDLE → first beat may transfer 1 cycle later.
  - last beat → done 1 cycle later.
  - done → earliest next capture is the following cycle, i.e. 2 idle-side cycles between packets.
- Back-pressure: out_ready=0 holds the beat. in_ready[owner]=0, so the source must hold it. No internal storage.
- Reset mid-XFER: abandon the packet immediately, no done pulse, return to IDLE.
- Single-beat packet (in_last on the first beat): XFER lasts 1 cycle if out_ready=1.

Optional Feature:
- Macro GBM_TRUNC_EN.
- Defined:
  - force_last = (beat_cnt == MAX_BEATS-1) in XFER.
  - The accepted beat at that count ends the burst.
  - done and trunc pulse together in RELEASE when the ending beat had in_last[owner]=0.
  - The beat counter is $clog2(MAX_BEATS) bits wide and saturates.
- Undefined: force_last=0, trunc tied 0, no beat counter; only in_last ends a packet.

Decomposition:
- Package gbm_pkg holds:
  - state enum {GBM_IDLE, GBM_XFER, GBM_RELEASE};
  - default parameter constants;
  - the IDX_W calculation helper.
- One sub-module, gbm_onehot_idx: combinational lowest-set-bit encoder N_REQ → IDX_W with a valid flag. Used for owner capture.

Test Plan:
- Reset and idle:
  - rst=0 for 2 cycles → all outputs 0.
  - rst=1, gnt=0 → busy stays 0.
- Basic packet:
  - gnt=4'b1000, requester 3 sends 3 beats 0xA1,0xA2,0xA3 (last on 0xA3), out_ready=1.
  - → owner=3, out_data follows the sequence, done pulses 1 cycle after 0xA3, in_ready[2:0]=0 throughout.
- Grant change while locked:
  - gnt=4'b0100 then gnt=4'b0001 mid-packet.
  - → owner stays 2, requester 0 sees in_ready=0; after done, requester 0 is captured.
- Back-pressure:
  - owner=1, out_ready toggles 1,0,0,1 over a 2-beat packet 0x11,0x22.
  - → each beat transfers exactly once, beat_cnt=2 at release, no duplicates.
- Multi-hot grant:
  - gnt=4'b0011 → owner=0, in_ready=4'b0001 while out_ready=1.
- Truncation (GBM_TRUNC_EN, MAX_BEATS=4):
  - requester 2 streams 6 beats with no in_last → out_last on the 4th beat, done and trunc pulse together, 5th beat not accepted.
  - Reset asserted mid-packet in a separate run → immediate IDLE, no done.

Source files
------------

// File: rtl/gbm_pkg.sv
// Shared types and defaults for grant_bus_mux: FSM state encoding, default sizes
// and the index-width helper.
package gbm_pkg;

    typedef enum logic [1:0] {
        GBM_IDLE,
        GBM_XFER,
        GBM_RELEASE
    } gbm_state_e;

    localparam int GBM_N_REQ     = 4;
    localparam int GBM_DATA_W    = 8;
    localparam int GBM_MAX_BEATS = 16;

    // Never returns 0, so a single requester still gets a 1-bit index.
    function automatic int gbm_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gbm_onehot_idx.sv
// Lowest-set-bit encoder: turns the arbiter grant vector into an owner index.
// vld_o reports whether any bit was set.
module gbm_onehot_idx
    import gbm_pkg::*;
#(
    parameter  int N_REQ = GBM_N_REQ,
    localparam int IDX_W = gbm_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    // Scan from the top so the lowest set bit is the last to write idx_o.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grant_bus_mux.sv
// grant_bus_mux: locks onto the granted requester and steers its packet onto one shared bus.
// Optional burst truncation at MAX_BEATS is enabled by defining GBM_TRUNC_EN.
module grant_bus_mux
    import gbm_pkg::*;
#(
    parameter  int N_REQ     = GBM_N_REQ,
    parameter  int DATA_W    = GBM_DATA_W,
    parameter  int MAX_BEATS = GBM_MAX_BEATS,
    localparam int IDX_W     = gbm_idx_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        gnt,
    input  logic [N_REQ-1:0]        in_valid,
    input  logic [N_REQ*DATA_W-1:0] in_data,
    input  logic [N_REQ-1:0]        in_last,
    output logic [N_REQ-1:0]        in_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        owner,
    output logic                    busy,
    output logic                    done,
    output logic                    trunc
);

    if (MAX_BEATS < 2) begin : g_bad_max_beats
        $error("grant_bus_mux: MAX_BEATS must be at least 2");
    end

    gbm_state_e       state_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             xfer;
    logic             accept;
    logic             force_last;

    gbm_onehot_idx #(.N_REQ(N_REQ)) u_gnt_idx (
        .vec_i (gnt),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    assign xfer      = (state_q == GBM_XFER);
    assign busy      = xfer;
    assign done      = (state_q == GBM_RELEASE);
    assign owner     = owner_q;
    assign out_valid = xfer & in_valid[owner_q];
    assign out_last  = xfer & (in_last[owner_q] | force_last);
    assign out_data  = xfer ? in_data[owner_q*DATA_W +: DATA_W] : '0;
    assign accept    = out_valid & out_ready;

    // Only the owner ever sees ready; the bus holds no beat of its own.
    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[owner_q] = out_ready;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= GBM_IDLE;
            owner_q <= '0;
        end else begin
            case (state_q)
                GBM_IDLE: begin
                    if (gnt_vld) begin
                        owner_q <= gnt_idx;
                        state_q <= GBM_XFER;
                    end
                end
                GBM_XFER: begin
                    if (accept && out_last) begin
                        state_q <= GBM_RELEASE;
                    end
                end
                GBM_RELEASE: state_q <= GBM_IDLE;
                default:     state_q <= GBM_IDLE;
            endcase
        end
    end

`ifdef GBM_TRUNC_EN
    localparam int             CNT_W   = gbm_idx_w(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS - 1);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             trunc_q, trunc_d;

    assign force_last = xfer && (beat_cnt_q == CNT_MAX);

    // trunc_q remembers that the ending beat carried no in_last of its own.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        trunc_d    = trunc_q;
        if (state_q == GBM_IDLE && gnt_vld) begin
            beat_cnt_d = '0;
            trunc_d    = 1'b0;
        end else if (accept) begin
            if (beat_cnt_q != CNT_MAX) begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
            if (out_last) begin
                trunc_d = force_last & ~in_last[owner_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt_q <= '0;
            trunc_q    <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            trunc_q    <= trunc_d;
        end
    end

    assign trunc = done & trunc_q;
`else
    assign force_last = 1'b0;
    assign trunc      = 1'b0;
`endif

endmodule

// File: tb/tb_grant_bus_mux.sv
// Scoreboard bench for grant_bus_mux: packets are queued as expected beats and release
// records when issued; a negedge monitor pops and compares whatever the bus presents.
module tb_grant_bus_mux;

    localparam int NR = 4;
    localparam int DW = 8;
`ifdef GBM_TRUNC_EN
    localparam int MB = 4;
`else
    localparam int MB = 16;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     gnt = '0;
    logic [NR-1:0]     in_valid = '0;
    logic [NR*DW-1:0]  in_data = '0;
    logic [NR-1:0]     in_last = '0;
    logic [NR-1:0]     in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic              out_ready = 1'b0;
    logic [1:0]        owner;
    logic              busy;
    logic              done;
    logic              trunc;

    always #5 clk = ~clk;

    grant_bus_mux #(.N_REQ(NR), .DATA_W(DW), .MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .gnt       (gnt),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .owner     (owner),
        .busy      (busy),
        .done      (done),
        .trunc     (trunc)
    );

    typedef struct {
        bit         is_end;
        int         own;
        logic [7:0] data;
        bit         last;
        bit         tr;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] pdata[$];
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, want);
        end
    endtask

    function automatic int lowest(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return 0;
    endfunction

    // Monitor: compares bus activity against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("done_in_reset", {31'd0, done}, 32'd0);
            end else if (busy) begin
                if (sbq.size() == 0 || sbq[0].is_end) begin
                    chk("busy_unexpected", {31'd0, busy}, 32'd0);
                end else begin
                    chk("owner_xfer", {30'd0, owner}, sbq[0].own);
                    chk("in_ready_xfer", {28'd0, in_ready}, out_ready ? (32'd1 << sbq[0].own) : 32'd0);
                    if (out_valid && out_ready) begin
                        e = sbq.pop_front();
                        chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
                        chk("beat_last", {31'd0, out_last}, {31'd0, e.last});
                    end
                end
            end else begin
                chk("idle_in_ready", {28'd0, in_ready}, 32'd0);
                chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
                chk("idle_out_data", {24'd0, out_data}, 32'd0);
                if (done) begin
                    if (sbq.size() == 0 || !sbq[0].is_end) begin
                        chk("unexpected_done", {31'd0, done}, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("release_owner", {30'd0, owner}, e.own);
                        chk("release_trunc", {31'd0, trunc}, {31'd0, e.tr});
                    end
                end else begin
                    chk("trunc_without_done", {31'd0, trunc}, 32'd0);
                end
            end
        end
    end

    task automatic clr_src();
        in_valid = '0;
        in_last  = '0;
        in_data  = '0;
    endtask

    // rmode: 0 = always valid/ready, 1 = random gaps, 2 = ready pattern 1,0,0,1.
    // abort_at >= 0 asserts reset once that many beats have been accepted.
    task automatic run_pkt(input logic [3:0] g, input logic [3:0] gj, input int rmode, input int abort_at);
        int r, len, n_exp, sent, cyc;
        bit tr, fire;
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_t e;
        r = lowest(g);
        len = pdata.size();
        n_exp = len;
        tr = 1'b0;
`ifdef GBM_TRUNC_EN
        if (len > MB) begin
            n_exp = MB;
            tr = 1'b1;
        end
`endif
        for (int k = 0; k < n_exp; k++) begin
            e = '{is_end: 1'b0, own: r, data: pdata[k], last: (k == n_exp - 1), tr: 1'b0};
            sbq.push_back(e);
        end
        e = '{is_end: 1'b1, own: r, data: 8'h00, last: 1'b0, tr: tr};
        sbq.push_back(e);

        gnt = g;
        @(posedge clk); #1;
        gnt = gj;
        sent = 0;
        cyc = 0;
        while (sent < n_exp && cyc < 400) begin
            if (abort_at >= 0 && sent == abort_at) begin
                rst = 1'b0;
                #1;
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
                chk("abort_in_ready", {28'd0, in_ready}, 32'd0);
                chk("abort_owner", {30'd0, owner}, 32'd0);
                sbq.delete();
                @(posedge clk); @(posedge clk); #1;
                gnt = '0;
                clr_src();
                rst = 1'b1;
                @(posedge clk); #1;
                return;
            end
            in_valid = 4'($urandom);
            in_data  = 32'($urandom);
            in_last  = 4'($urandom);
            in_valid[r] = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data[r*DW +: DW] = pdata[sent];
            in_last[r] = (sent == len - 1);
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 2) ? pat[cyc % 4] : ($urandom_range(0, 2) != 0);
            #1;
            fire = in_valid[r] & in_ready[r];
            @(posedge clk); #1;
            if (fire) sent++;
            cyc++;
        end
        chk("pkt_beats_accepted", sent, n_exp);
        gnt = '0;
        if (sent < n_exp) begin
            rst = 1'b0;
            sbq.delete();
            @(posedge clk); #1;
            rst = 1'b1;
            clr_src();
            return;
        end
        if (len > n_exp) begin
            repeat (2) begin
                clr_src();
                in_valid[r] = 1'b1;
                in_data[r*DW +: DW] = pdata[n_exp];
                out_ready = 1'b1;
                @(posedge clk); #1;
            end
        end
        clr_src();
        out_ready = 1'($urandom);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] g;
        int len;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_trunc", {31'd0, trunc}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
        chk("rst_owner", {30'd0, owner}, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_gnt_busy", {31'd0, busy}, 32'd0);
        end
        @(posedge clk); #1;

        pdata = '{8'hA1, 8'hA2, 8'hA3};
        run_pkt(4'b1000, 4'b0000, 0, -1);

        pdata = '{8'h31, 8'h32, 8'h33, 8'h34};
        run_pkt(4'b0100, 4'b0001, 1, -1);
        pdata = '{8'h41, 8'h42};
        run_pkt(4'b0001, 4'b0001, 0, -1);

        pdata = '{8'h11, 8'h22};
        run_pkt(4'b0010, 4'b0000, 2, -1);

        pdata = '{8'h5A, 8'h5B};
        run_pkt(4'b0011, 4'b0000, 0, -1);

        pdata = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
        run_pkt(4'b0100, 4'b0011, 0, -1);

        pdata = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
        run_pkt(4'b0100, 4'b1000, 0, 2);

        for (int p = 0; p < 40; p++) begin
            g = 4'($urandom_range(1, 15));
            len = $urandom_range(1, 7);
            pdata.delete();
            for (int k = 0; k < len; k++) pdata.push_back(8'($urandom));
            run_pkt(g, 4'($urandom), 1, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
